// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Operand/result handshake bundle for the sequential BCD converter.
// Revision : 1.0
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_data;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_neg;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_bcd, out_neg, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_bcd, out_neg, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential double-dabble binary (signed/unsigned) to BCD converter.
// Revision : 1.0
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bin_to_bcd_seq_if.slave     bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CONV = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BIN_W-1:0]  mag_q, mag_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  out_bcd_q, out_bcd_d;
    logic              out_neg_q, out_neg_d;
    logic              out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]  w_corr;
    logic [ACC_W-1:0]  w_acc_shift;
    logic              w_ovf;
    logic              w_in_neg;
    logic              w_accept;
    logic              w_last;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;

    // Add-3 correction of every digit that would reach 10 or more when doubled.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_corr[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                            : acc_q[4*i +: 4];
    end

    // A set MSB in the top corrected digit is a decimal carry lost off the end.
    assign w_acc_shift = {w_corr[ACC_W-2:0], mag_q[BIN_W-1]};
    assign w_ovf       = ovf_q | w_corr[ACC_W-1];
    assign w_in_neg    = bus.in_signed & bus.in_data[BIN_W-1];
    assign w_accept    = (state_q == C_IDLE) && bus.in_valid;
    assign w_last      = (state_q == C_CONV) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (bus.in_valid)  state_d = C_CONV;
            C_CONV:  if (cnt_q == '0)   state_d = C_DONE;
            C_DONE:  if (bus.out_ready) state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    // Output decode, from registered state only
    always_comb begin
        w_in_ready  = (state_q == C_IDLE);
        w_out_valid = (state_q == C_DONE);
        w_busy      = (state_q != C_IDLE);
    end

    always_comb begin
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        out_bcd_d = out_bcd_q;
        out_neg_d = out_neg_q;
        out_ovf_d = out_ovf_q;
        if (w_accept) begin
            // Negating the most-negative value wraps to itself, the correct magnitude.
            mag_d = w_in_neg ? ('0 - bus.in_data) : bus.in_data;
            neg_d = w_in_neg;
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = CNT_W'(BIN_W - 1);
        end else if (state_q == C_CONV) begin
            acc_d = w_acc_shift;
            mag_d = {mag_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            ovf_d = w_ovf;
            if (w_last) begin
                out_bcd_d = w_acc_shift;
                out_neg_d = neg_q;
                out_ovf_d = w_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            out_bcd_q <= '0;
            out_neg_q <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            out_bcd_q <= out_bcd_d;
            out_neg_q <= out_neg_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
`default_nettype wire
